// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL AFC/lock sequencer: state encodings, fixed
// sequence lengths and status field widths used by the I2C register map.
package pll_seq_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned STATUS_FLAG_W  = 4;
  localparam int unsigned AFC_RST_CYCLES = 8;
  localparam int unsigned RELOCK_WAIT    = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_AFC_RST   = 3'd1,
    ST_AFC_START = 3'd2,
    ST_AFC_BUSY  = 3'd3,
    ST_WAIT_LOCK = 3'd4,
    ST_LOCKED    = 3'd5,
    ST_LOST      = 3'd6
  } state_t;

  // Status word as laid out for I2C readback (lol_count is mapped separately).
  typedef struct packed {
    logic [STATE_W-1:0] state;
    logic               afc_rst;
    logic               afc_start;
    logic               pll_locked;
    logic               err_timeout;
  } seq_status_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_nff.sv
// Multi-flop synchronizer for a single asynchronous level, reset to 0.
module sync_nff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// AFC calibration sequencer and lock qualifier for the PLL core (40 MHz domain).
// Build option PLL_AUTO_RELOCK_EN: LOST recalibrates/relocks after RELOCK_WAIT cycles.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_CNT    = 1000,
  parameter int unsigned UNLOCK_CNT  = 4,
  parameter int unsigned AFC_TIMEOUT = 4096,
  parameter int unsigned LOL_W       = 8
) (
  input  logic               clk40,
  input  logic               rstn,
  input  logic               enable,
  input  logic               afc_manual,
  input  logic               instlock,
  input  logic               afc_busy,
  input  logic               lol_clear,
  output logic               afc_rst,
  output logic               afc_start,
  output logic               pll_locked,
  output logic               err_timeout,
  output logic [LOL_W-1:0]   lol_count,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned CNT_MAX = max_u(max_u(LOCK_CNT, AFC_TIMEOUT),
                                          max_u(UNLOCK_CNT, max_u(AFC_RST_CYCLES, RELOCK_WAIT)));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic             lock_s, busy_s;
  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             seen_q, seen_nxt;
  logic             afc_rst_nxt, afc_start_nxt, locked_nxt, err_nxt;
  logic [LOL_W-1:0] lol_nxt;
  logic             lost_evt, timeout_evt;

  sync_nff #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk(clk40), .rst_n(rstn), .d(instlock), .q(lock_s)
  );

  sync_nff #(.STAGES(SYNC_STAGES)) u_sync_busy (
    .clk(clk40), .rst_n(rstn), .d(afc_busy), .q(busy_s)
  );

  // Next state, shared phase counter, and next values of every registered output.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    seen_nxt    = seen_q;
    lol_nxt     = lol_count;
    err_nxt     = err_timeout;
    lost_evt    = 1'b0;
    timeout_evt = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (enable) state_nxt = afc_manual ? ST_WAIT_LOCK : ST_AFC_RST;
      end
      ST_AFC_RST: begin
        if (cnt_q == CNT_W'(AFC_RST_CYCLES - 1)) begin
          state_nxt = ST_AFC_START;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ST_AFC_START: begin
        state_nxt = ST_AFC_BUSY;
        cnt_nxt   = '0;
        seen_nxt  = 1'b0;
      end
      ST_AFC_BUSY: begin
        // Completion needs a synced rise followed by a fall; the timer covers both phases.
        if (seen_q && !busy_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt_q == CNT_W'(AFC_TIMEOUT - 1)) begin
          state_nxt   = ST_AFC_RST;
          cnt_nxt     = '0;
          timeout_evt = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
          if (busy_s) seen_nxt = 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_nxt = '0;
        end else if (cnt_q == CNT_W'(LOCK_CNT - 1)) begin
          state_nxt = ST_LOCKED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (lock_s) begin
          cnt_nxt = '0;
        end else if (cnt_q == CNT_W'(UNLOCK_CNT - 1)) begin
          state_nxt = ST_LOST;
          cnt_nxt   = '0;
          lost_evt  = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ST_LOST: begin
`ifdef PLL_AUTO_RELOCK_EN
        if (cnt_q == CNT_W'(RELOCK_WAIT - 1)) begin
          state_nxt = afc_manual ? ST_WAIT_LOCK : ST_AFC_RST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
`else
        cnt_nxt = '0;
`endif
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end

    if (timeout_evt) err_nxt = 1'b1;
    if (lost_evt && (lol_count != {LOL_W{1'b1}})) lol_nxt = lol_count + LOL_W'(1);
    if (lol_clear) begin
      lol_nxt = '0;
      err_nxt = 1'b0;
    end

    // Outputs follow the next state so they change on the same edge as the state.
    afc_rst_nxt   = (state_nxt == ST_IDLE) || (state_nxt == ST_AFC_RST);
    afc_start_nxt = (state_nxt == ST_AFC_START);
    locked_nxt    = (state_nxt == ST_LOCKED);
  end

  always_ff @(posedge clk40 or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
      afc_rst     <= 1'b1;
      afc_start   <= 1'b0;
      pll_locked  <= 1'b0;
      err_timeout <= 1'b0;
      lol_count   <= '0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      seen_q      <= seen_nxt;
      afc_rst     <= afc_rst_nxt;
      afc_start   <= afc_start_nxt;
      pll_locked  <= locked_nxt;
      err_timeout <= err_nxt;
      lol_count   <= lol_nxt;
    end
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: vector table plus hand-written corner sequences.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  // Short lock qualification keeps the 300-event saturation run within budget.
  localparam int unsigned T_LOCK = 100;
  localparam int unsigned T_TO   = 4096;
  localparam int unsigned T_LOLW = 8;

  localparam int S_ST = 0, S_RST = 1, S_START = 2, S_LOCKED = 3, S_ERR = 4, S_LOL = 5, S_NONE = -1;

  logic              clk40 = 1'b0;
  logic              rstn, enable, afc_manual, instlock, afc_busy, lol_clear;
  logic              afc_rst, afc_start, pll_locked, err_timeout;
  logic [T_LOLW-1:0] lol_count;
  logic [2:0]        state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    int          sig;
    int unsigned val;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic       en, man, lock, busy;
    int         hold;
    logic [2:0] st;
    logic       rst, start, locked;
  } vec_t;
  vec_t vecs[9];

  pll_lock_sequencer #(
    .SYNC_STAGES(2), .LOCK_CNT(T_LOCK), .UNLOCK_CNT(4), .AFC_TIMEOUT(T_TO), .LOL_W(T_LOLW)
  ) dut (
    .clk40(clk40), .rstn(rstn), .enable(enable), .afc_manual(afc_manual),
    .instlock(instlock), .afc_busy(afc_busy), .lol_clear(lol_clear),
    .afc_rst(afc_rst), .afc_start(afc_start), .pll_locked(pll_locked),
    .err_timeout(err_timeout), .lol_count(lol_count), .state(state)
  );

  always #5 clk40 = ~clk40;

  function automatic int unsigned obs(input int sig);
    case (sig)
      S_ST:     return int'(state);
      S_RST:    return int'(afc_rst);
      S_START:  return int'(afc_start);
      S_LOCKED: return int'(pll_locked);
      S_ERR:    return int'(err_timeout);
      S_LOL:    return int'(lol_count);
      default:  return 0;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk40);
  endtask

  task automatic expect_sig(input string nm, input int sig, input int unsigned v);
    exp_t e;
    e.nm = nm; e.sig = sig; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check_pop_val(input int unsigned act);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=%0d", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s actual=%0d required=%0d", e.nm, act, e.val);
      end
    end
  endtask

  task automatic check_all();
    while (sb_q.size() > 0) check_pop_val(obs(sb_q[0].sig));
  endtask

  task automatic check_now(input string nm, input int sig, input int unsigned v);
    expect_sig(nm, sig, v);
    check_all();
  endtask

  // Cycles until the selected output goes nonzero, bounded by budget.
  task automatic measure(input int sig, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk40);
      n++;
    end while (obs(sig) == 0 && n < budget);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk40);
      n++;
    end
    if (state !== s) begin
      checks++;
      errors++;
      $display("FAIL wait_state actual=%0d required=%0d", state, s);
    end
  endtask

  task automatic drop_lock(input int n);
    instlock = 1'b0;
    tick(n);
    instlock = 1'b1;
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0,  3, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 20, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0,  7, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0,  1, 3'd0, 1'b1, 1'b0, 1'b0};

    rstn = 1'b0; enable = 1'b0; afc_manual = 1'b0;
    instlock = 1'b0; afc_busy = 1'b0; lol_clear = 1'b0;
    tick(3);
    check_now("rst_state", S_ST, 0);
    check_now("rst_afc_rst", S_RST, 1);
    check_now("rst_afc_start", S_START, 0);
    check_now("rst_locked", S_LOCKED, 0);
    check_now("rst_err", S_ERR, 0);
    check_now("rst_lol", S_LOL, 0);
    rstn = 1'b1;
    tick(1);

    // Level vectors: manual bypass, AFC reset length, start pulse, abort from AFC_BUSY.
    for (int i = 0; i < 9; i++) begin
      enable = vecs[i].en; afc_manual = vecs[i].man;
      instlock = vecs[i].lock; afc_busy = vecs[i].busy;
      expect_sig($sformatf("vec%0d_state", i), S_ST, vecs[i].st);
      expect_sig($sformatf("vec%0d_afc_rst", i), S_RST, vecs[i].rst);
      expect_sig($sformatf("vec%0d_afc_start", i), S_START, vecs[i].start);
      expect_sig($sformatf("vec%0d_locked", i), S_LOCKED, vecs[i].locked);
      tick(vecs[i].hold);
      check_all();
    end

    // Nominal calibration then lock qualification.
    afc_manual = 1'b0; enable = 1'b1;
    wait_state(3'd3, 30);
    afc_busy = 1'b1;
    tick(200);
    check_now("busy_hold_state", S_ST, 3);
    afc_busy = 1'b0;
    wait_state(3'd4, 10);
    check_now("wait_lock_unlocked", S_LOCKED, 0);
    instlock = 1'b1;
    expect_sig("lock_latency", S_NONE, T_LOCK + 2);
    measure(S_LOCKED, T_LOCK + 50, n);
    check_pop_val(n);
    check_now("locked_state", S_ST, 5);

    // Short dropout is tolerated, four synced cycles is loss of lock.
    drop_lock(3);
    tick(6);
    check_now("short_drop_state", S_ST, 5);
    check_now("short_drop_locked", S_LOCKED, 1);
    check_now("short_drop_lol", S_LOL, 0);
    drop_lock(4);
    wait_state(3'd6, 10);
    check_now("lost_locked", S_LOCKED, 0);
    check_now("lost_lol", S_LOL, 1);
    check_now("lost_afc_rst", S_RST, 0);
`ifdef PLL_AUTO_RELOCK_EN
    expect_sig("relock_wait", S_NONE, RELOCK_WAIT);
    measure(S_RST, 40, n);
    check_pop_val(n);
    check_now("relock_state", S_ST, 1);
`else
    tick(40);
    check_now("lost_terminal_state", S_ST, 6);
    check_now("lost_terminal_rst", S_RST, 0);
`endif
    enable = 1'b0;
    tick(1);
    check_now("disable_state", S_ST, 0);
    check_now("disable_afc_rst", S_RST, 1);

    // One-cycle glitch at the last count restarts qualification.
    afc_manual = 1'b1; enable = 1'b1; instlock = 1'b0;
    tick(2);
    check_now("manual_wait_state", S_ST, 4);
    instlock = 1'b1;
    tick(T_LOCK - 1);
    instlock = 1'b0;
    tick(1);
    instlock = 1'b1;
    expect_sig("glitch_lock_latency", S_NONE, T_LOCK + 2);
    measure(S_LOCKED, 3 * T_LOCK, n);
    check_pop_val(n);
    check_now("glitch_locked_state", S_ST, 5);

    // Clear, then saturate the loss-of-lock counter.
    lol_clear = 1'b1;
    tick(1);
    lol_clear = 1'b0;
    check_now("lol_cleared", S_LOL, 0);
    for (int i = 0; i < 300; i++) begin
      drop_lock(4);
      wait_state(3'd6, 10);
      if (i == 0) check_now("lol_first", S_LOL, 1);
      if (i == 254) check_now("lol_at_max", S_LOL, 255);
      enable = 1'b0;
      tick(1);
      enable = 1'b1;
      wait_state(3'd5, T_LOCK + 20);
    end
    check_now("lol_saturated", S_LOL, 255);

    // Clear coincident with the increment edge wins.
    drop_lock(4);
    tick(1);
    lol_clear = 1'b1;
    tick(1);
    lol_clear = 1'b0;
    check_now("clear_vs_inc_state", S_ST, 6);
    check_now("clear_vs_inc_lol", S_LOL, 0);

    // AFC busy never rises: timeout, sticky error, retry through AFC_RST.
    enable = 1'b0;
    tick(1);
    afc_manual = 1'b0; instlock = 1'b0; afc_busy = 1'b0; enable = 1'b1;
    wait_state(3'd3, 30);
    expect_sig("timeout_latency", S_NONE, T_TO);
    measure(S_ERR, T_TO + 100, n);
    check_pop_val(n);
    check_now("timeout_retry_state", S_ST, 1);
    check_now("timeout_retry_rst", S_RST, 1);
    lol_clear = 1'b1;
    tick(1);
    lol_clear = 1'b0;
    check_now("err_cleared", S_ERR, 0);

    // Asynchronous reset during the start pulse cuts it immediately.
    wait_state(3'd2, 20);
    check_now("start_pulse", S_START, 1);
    check_now("start_no_rst", S_RST, 0);
    rstn = 1'b0;
    #1;
    check_now("async_rst_state", S_ST, 0);
    check_now("async_rst_start", S_START, 0);
    check_now("async_rst_afc_rst", S_RST, 1);
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
